game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Game-flow controller feeding the UI overlay renderer: owns the screen state machine and the
//  per-stage progress (keys found, lives, current task, stage unlocks). Consumes decoded menu
//  clicks and gameplay hit pulses. Drives state/key_find/life/todo/play_valid for the renderer.
// PARAMETERS
//  TIME_LIMIT  90  stage time budget in tick_1hz periods (1..127); expiry -> FAIL
//  MAX_LIFE    3   lives at stage-3 entry (1..3)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  click_valid in   1  one-cycle pulse: menu item clicked
//  click_id    in   3  0 STAGE1,1 STAGE2,2 STAGE3,3 NEXT,4 BACK,5 RETRY,6 STAFF,7 HELP
//  tick_1hz    in   1  one-cycle pulse per second
//  key_hit     in   1  pulse: player touched a key
//  light_hit   in   1  pulse: player touched the light
//  door_hit    in   1  pulse: player reached the door
//  trap_hit    in   1  pulse: player hit a trap (stage 3 only)
//  state       out  4  TITLE0 STAFF1 STAGE1 2 SUCC1 3 STAGE2 4 SUCC2 5 STAGE3 6 SUCC3 7 FAIL8 HELP9
//  key_find    out  2  keys collected in current stage, 0..3
//  life        out  2  lives remaining (meaningful in STAGE3)
//  todo        out  2  NONE0 FIND_KEY1 FIND_LIGHT2 FIND_DOOR3
//  play_valid  out  4  stage unlock mask; bit1=stage1, bit2=stage2, bit3=stage3, bit0 always 0
//  time_left   out  7  seconds remaining in current stage
// BEHAVIOUR
//  - All outputs registered; reaction to any input pulse visible on the next clk edge (1 cycle).
//  - Reset: state=TITLE, key_find=0, life=MAX_LIFE, todo=NONE, play_valid=4'b0010,
//    time_left=TIME_LIMIT, last_stage=STAGE1. play_valid survives everything except rst.
//  - TITLE: STAGE1 always; STAGE2 if play_valid[2]; STAGE3 if play_valid[3]; STAFF; HELP.
//    Locked-stage clicks ignored. HELP/STAFF: BACK -> TITLE. Non-listed click_ids ignored.
//  - Stage entry (any path): key_find=0, life=MAX_LIFE, time_left=TIME_LIMIT, last_stage=target;
//    todo=FIND_LIGHT for STAGE2, FIND_KEY otherwise.
//  - In STAGEn: key_hit with todo==FIND_KEY increments key_find; on reaching 3, todo=FIND_DOOR.
//    light_hit with todo==FIND_LIGHT -> todo=FIND_KEY (STAGE2 only). door_hit with
//    todo==FIND_DOOR -> SUCCESSn, todo=NONE. Hits not matching todo are ignored.
//  - STAGE3 only: trap_hit decrements life; life reaching 0 -> FAIL same edge. Ignored elsewhere.
//  - tick_1hz in STAGEn decrements time_left; decrement from 1 to 0 -> FAIL. Frozen outside stages.
//  - Priority same cycle in a stage: door success > trap/timeout fail > key/light progress.
//  - SUCCESS1 entry sets play_valid[2]; SUCCESS2 entry sets play_valid[3].
//  - SUCCESS1/2: NEXT -> STAGE2/STAGE3, BACK -> TITLE. SUCCESS3: NEXT -> STAFF.
//  - FAIL: RETRY -> last_stage (with full stage entry), BACK -> TITLE.
//  - Clicks ignored in STAGEn; hit/tick pulses ignored outside STAGEn.
//  - rst mid-stage returns to reset values immediately on that edge, unlocks cleared.
//  - Illegal state codes (10..15) -> TITLE next cycle.
// STRUCTURE
//  - game_pkg: state codes, todo codes, click_id codes (shared with renderer and click decoder).
//  - Sub-module stage_timer: load/enable/tick in, time_left and expire pulse out.
//  - game_ctrl: single next-state always block plus registered progress counters.
// TESTING
//  - rst; click STAGE2 at TITLE -> state stays 0; click STAGE1 -> state=2, todo=1, time_left=90.
//  - STAGE1: 3x key_hit -> key_find=3, todo=3; door_hit -> state=3, play_valid=4'b0110.
//  - STAGE2: key_hit before light_hit ignored (key_find=0); light_hit -> todo=1; finish -> play_valid=4'b1110.
//  - STAGE3: 3x trap_hit -> life 2,1 then state=8; RETRY -> state=6, life=3, key_find=0.
//  - STAGE3 todo=3, life=1: door_hit+trap_hit same cycle -> state=7 (SUCCESS3), life=1.
//  - TIME_LIMIT=2: two tick_1hz in STAGE1 -> state=8; further ticks leave time_left=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: screen state, task and menu click codes shared by controller, renderer and click decoder
package game_pkg;
  typedef enum logic [3:0] {
    TITLE  = 4'd0,
    STAFF  = 4'd1,
    STAGE1 = 4'd2,
    SUCC1  = 4'd3,
    STAGE2 = 4'd4,
    SUCC2  = 4'd5,
    STAGE3 = 4'd6,
    SUCC3  = 4'd7,
    FAIL   = 4'd8,
    HELP   = 4'd9
  } state_t;
  typedef enum logic [1:0] {NONE, FIND_KEY, FIND_LIGHT, FIND_DOOR} todo_t;
  localparam logic [2:0] C_STAGE1 = 3'd0;
  localparam logic [2:0] C_STAGE2 = 3'd1;
  localparam logic [2:0] C_STAGE3 = 3'd2;
  localparam logic [2:0] C_NEXT   = 3'd3;
  localparam logic [2:0] C_BACK   = 3'd4;
  localparam logic [2:0] C_RETRY  = 3'd5;
  localparam logic [2:0] C_STAFF  = 3'd6;
  localparam logic [2:0] C_HELP   = 3'd7;
endpackage

// File: rtl/game_ctrl_stage_timer.sv
// stage_timer: stage countdown (in clk rst load en tick, out time_left[7] and combinational expire on the 1->0 tick)
module stage_timer #(
  parameter int TIME_LIMIT = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic       tick,
  output logic [6:0] time_left,
  output logic       expire
);
  assign expire = en && tick && time_left == 7'd1;
  always_ff @(posedge clk) begin
    if (rst || load) time_left <= 7'(TIME_LIMIT);
    else if (en && tick && time_left != 7'd0) time_left <= time_left - 7'd1;
  end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: screen FSM and stage progress (in click_valid/click_id, tick_1hz, key/light/door/trap hits; out state, key_find, life, todo, play_valid, time_left)
module game_ctrl
  import game_pkg::*;
#(
  parameter int TIME_LIMIT = 90,
  parameter int MAX_LIFE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       click_valid,
  input  logic [2:0] click_id,
  input  logic       tick_1hz,
  input  logic       key_hit,
  input  logic       light_hit,
  input  logic       door_hit,
  input  logic       trap_hit,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic [1:0] life,
  output logic [1:0] todo,
  output logic [3:0] play_valid,
  output logic [6:0] time_left
);
  state_t st, ns, tgt, ls, nls;
  todo_t td, nt;
  logic [1:0] nk, nl;
  logic [3:0] npv;
  logic enter, expire, in_stage, door_ok, trap;
  assign state = st;
  assign todo = td;
  assign in_stage = st == STAGE1 || st == STAGE2 || st == STAGE3;
  assign door_ok = door_hit && td == FIND_DOOR;
  assign trap = trap_hit && st == STAGE3;
  stage_timer #(.TIME_LIMIT(TIME_LIMIT)) u_timer (
    .clk(clk), .rst(rst), .load(enter), .en(in_stage), .tick(tick_1hz),
    .time_left(time_left), .expire(expire)
  );
  always_comb begin
    ns = st;
    nk = key_find;
    nl = life;
    nt = td;
    npv = play_valid;
    nls = ls;
    tgt = STAGE1;
    enter = 1'b0;
    case (st)
      TITLE: if (click_valid) begin
        if (click_id == C_STAGE1 || (click_id == C_STAGE2 && play_valid[2]) || (click_id == C_STAGE3 && play_valid[3])) begin
          enter = 1'b1;
          tgt = click_id == C_STAGE1 ? STAGE1 : click_id == C_STAGE2 ? STAGE2 : STAGE3;
        end
        else if (click_id == C_STAFF) ns = STAFF;
        else if (click_id == C_HELP) ns = HELP;
      end
      STAFF, HELP: if (click_valid && click_id == C_BACK) ns = TITLE;
      STAGE1, STAGE2, STAGE3: if (door_ok) begin
        ns = st == STAGE1 ? SUCC1 : st == STAGE2 ? SUCC2 : SUCC3;
        nt = NONE;
        npv = play_valid | (st == STAGE1 ? 4'b0100 : st == STAGE2 ? 4'b1000 : 4'b0000);
      end
      else begin
        if (trap) nl = life - 2'd1;
        if ((trap && life == 2'd1) || expire) ns = FAIL;
        else begin
          if (key_hit && td == FIND_KEY) begin
            nk = key_find + 2'd1;
            if (key_find == 2'd2) nt = FIND_DOOR;
          end
          if (light_hit && td == FIND_LIGHT && st == STAGE2) nt = FIND_KEY;
        end
      end
      SUCC1, SUCC2: if (click_valid) begin
        if (click_id == C_NEXT) begin
          enter = 1'b1;
          tgt = st == SUCC1 ? STAGE2 : STAGE3;
        end
        else if (click_id == C_BACK) ns = TITLE;
      end
      SUCC3: if (click_valid && click_id == C_NEXT) ns = STAFF;
      FAIL: if (click_valid) begin
        if (click_id == C_RETRY) begin
          enter = 1'b1;
          tgt = ls;
        end
        else if (click_id == C_BACK) ns = TITLE;
      end
      default: ns = TITLE;
    endcase
    if (enter) begin
      ns = tgt;
      nk = 2'd0;
      nl = 2'(MAX_LIFE);
      nt = tgt == STAGE2 ? FIND_LIGHT : FIND_KEY;
      nls = tgt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= TITLE;
      key_find <= 2'd0;
      life <= 2'(MAX_LIFE);
      td <= NONE;
      play_valid <= 4'b0010;
      ls <= STAGE1;
    end
    else begin
      st <= ns;
      key_find <= nk;
      life <= nl;
      td <= nt;
      play_valid <= npv;
      ls <= nls;
    end
  end
endmodule
